pulse_channel: RTL and testbench
================================

Name: pulse_channel

Overview:
Parametrised successor to the fixed 2-bit duty cycler: a complete square-wave voice for the sound chip. It has a programmable frequency divider, a STEPS-position phase sequencer and four selectable duty patterns. Supports trigger restart, enable gating and amplitude scaling. Its output feeds the mixer; the step strobe is available to envelope/sweep logic.

Parameters:
FREQ_WIDTH, 11, width of frequency register; step period = PRESCALE*(2^FREQ_WIDTH - freq) clk cycles
STEPS, 8, phase positions per waveform period; power of two, >= 8
PRESCALE, 4, clk cycles per timer tick; >= 1
VOL_WIDTH, 4, width of volume input and out

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  channel on; low forces out to 0 and freezes prescaler/timer/phase
trigger  input  1  single-cycle restart pulse
freq  input  FREQ_WIDTH  frequency code
duty_cycle  input  2  pattern select: 0=12.5%, 1=25%, 2=50%, 3=75%
volume  input  VOL_WIDTH  amplitude applied when wave is high
out  output  VOL_WIDTH  registered sample
step_strobe  output  1  one-cycle pulse on each phase advance

Behaviour:
- Reset (async, rst_n=0): out=0, step_strobe=0, prescaler=0, phase=0, timer=2^FREQ_WIDTH - freq sampled at reset release (first clk with rst_n=1 loads it); no strobe until first full period.
- Timer width FREQ_WIDTH+1 bits so freq=0 gives 2^FREQ_WIDTH ticks; freq=2^FREQ_WIDTH-1 gives 1 tick.
- Prescaler: counts 0..PRESCALE-1 while enable=1; wrap = tick.
- On tick: if timer<=1, reload timer=2^FREQ_WIDTH - freq, phase=(phase+1) mod STEPS, assert step_strobe next cycle; else timer decrements.
- freq changes take effect only at next reload or trigger, never mid-count.
- Pattern high count H: duty 0 -> STEPS/8, 1 -> STEPS/4, 2 -> STEPS/2, 3 -> 3*STEPS/4. Wave high when phase < H.
- duty_cycle and volume changes take effect on the next out update (no waiting for period boundary).
- out registered: out(n+1) = (enable && wave_high(phase(n))) ? volume(n) : 0. One clk latency from phase/duty/volume to out.
- Phase wraps STEPS-1 -> 0 silently (no extra strobe).
- trigger=1 (any enable state): prescaler=0, phase=0, timer reloaded from current freq; no step_strobe that cycle. Trigger beats a coincident expiry: no phase advance, no strobe.
- enable=0: counters hold values, step_strobe=0, out=0 next cycle. Re-enable resumes from held state.
- Reset mid-period: immediate async clear of out/strobe/phase/prescaler; no residual strobe after release.
- step_strobe never high two consecutive cycles unless PRESCALE=1 and timer reload value=1.

Test Plan:
- Defaults, freq=2046, duty=2, volume=15, enable=1, trigger pulse: step every 8 clks, strobe every 8 clks; out=15 for 32 clks, 0 for 32 clks, period 64 clks, repeating.
- Sweep duty 0..3 at freq=2046, volume=9, 300 clks each: high time per 64-clk period = 8, 16, 32, 48 clks; out values only 0 or 9.
- freq=0 with PRESCALE=4: strobe spacing 8192 clks; freq=2047: strobe every 4 clks, 32-clk period.
- Change freq 2046 -> 2044 mid-step: current step finishes at the old 8-clk spacing; subsequent steps at 16-clk spacing.
- Trigger coincident with timer expiry at phase 5: phase becomes 0, no strobe; next strobe exactly one full step period later.
- enable low for 20 clks mid-period, and separately rst_n low mid-period: with enable low, out=0 from next clk, and after re-enable the strobe timing resumes shifted by 20 clks. With rst_n low, out/step_strobe=0 immediately (asynchronously); after release, phase=0.

Source files
------------

// File: rtl/pulse_channel.sv
// Square-wave voice: prescaled down-counting step timer, STEPS-position phase
// sequencer, four duty patterns and volume gating into a registered sample.
module pulse_channel #(
  parameter int FREQ_WIDTH = 11,
  parameter int STEPS      = 8,
  parameter int PRESCALE   = 4,
  parameter int VOL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  trigger,
  input  logic [FREQ_WIDTH-1:0] freq,
  input  logic [1:0]            duty_cycle,
  input  logic [VOL_WIDTH-1:0]  volume,
  output logic [VOL_WIDTH-1:0]  out,
  output logic                  step_strobe
);

  localparam int PW  = $clog2(STEPS);
  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TW  = FREQ_WIDTH + 1;

  logic [PSW-1:0] prescaler;
  logic [TW-1:0]  timer;
  logic [TW-1:0]  reload;
  logic [PW-1:0]  phase;
  logic [PW-1:0]  high_cnt;
  logic           load_pend;
  logic           tick;
  logic           wave_high;

  // One extra timer bit so freq=0 still yields 2^FREQ_WIDTH ticks.
  assign reload    = (TW'(1) << FREQ_WIDTH) - TW'(freq);
  assign tick      = enable && (prescaler == PSW'(PRESCALE - 1));
  assign wave_high = (phase < high_cnt);

  always_comb begin
    high_cnt = PW'(STEPS / 8);
    case (duty_cycle)
      2'd0:    high_cnt = PW'(STEPS / 8);
      2'd1:    high_cnt = PW'(STEPS / 4);
      2'd2:    high_cnt = PW'(STEPS / 2);
      default: high_cnt = PW'((3 * STEPS) / 4);
    endcase
  end

  // load_pend makes the first clock after reset release sample freq into the timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler   <= '0;
      timer       <= '0;
      phase       <= '0;
      load_pend   <= 1'b1;
      step_strobe <= 1'b0;
      out         <= '0;
    end else begin
      out         <= (enable && wave_high) ? volume : '0;
      step_strobe <= 1'b0;
      if (load_pend || trigger) begin
        load_pend <= 1'b0;
        prescaler <= '0;
        timer     <= reload;
        phase     <= '0;
      end else if (enable) begin
        prescaler <= tick ? '0 : prescaler + 1'b1;
        if (tick) begin
          if (timer <= TW'(1)) begin
            timer       <= reload;
            phase       <= phase + 1'b1;
            step_strobe <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_channel.sv
// Randomised and directed bench for pulse_channel against a clock-count
// reference model (step every PRESCALE*(2^FW-freq) enabled clocks).
module tb_pulse_channel;
  localparam int FW    = 11;
  localparam int STEPS = 8;
  localparam int PS    = 4;
  localparam int VW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          trigger = 1'b0;
  logic [FW-1:0] freq = 11'd2046;
  logic [1:0]    duty_cycle = 2'd2;
  logic [VW-1:0] volume = 4'd15;
  logic [VW-1:0] out;
  logic          step_strobe;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int m_phase, m_cnt, m_period, m_out;
  bit m_init, m_strobe;

  always #5 clk = ~clk;

  pulse_channel #(.FREQ_WIDTH(FW), .STEPS(STEPS), .PRESCALE(PS), .VOL_WIDTH(VW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .trigger(trigger), .freq(freq),
    .duty_cycle(duty_cycle), .volume(volume), .out(out), .step_strobe(step_strobe)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int high_steps(input int d);
    case (d)
      0:       return STEPS / 8;
      1:       return STEPS / 4;
      2:       return STEPS / 2;
      default: return (3 * STEPS) / 4;
    endcase
  endfunction

  function automatic int step_clks(input int f);
    return PS * ((1 << FW) - f);
  endfunction

  task automatic model_reset();
    m_init = 1; m_phase = 0; m_cnt = 0; m_period = 0; m_out = 0; m_strobe = 0;
  endtask

  task automatic model_step();
    m_out    = (enable && m_phase < high_steps(duty_cycle)) ? int'(volume) : 0;
    m_strobe = 0;
    if (m_init || trigger) begin
      m_init = 0; m_phase = 0; m_cnt = 0; m_period = step_clks(freq);
    end else if (enable) begin
      m_cnt++;
      if (m_cnt == m_period) begin
        m_cnt = 0;
        m_phase = (m_phase + 1) % STEPS;
        m_period = step_clks(freq);
        m_strobe = 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("out", out, m_out);
    chk("step_strobe", step_strobe, m_strobe);
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    cycle();
    trigger = 1'b0;
  endtask

  task automatic wait_strobe(input int budget, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!step_strobe && n < budget);
    if (!step_strobe) chk("strobe_timeout", step_strobe, 1);
  endtask

  task automatic count_high(input int cycles, input int level, output int hi);
    hi = 0;
    for (int i = 0; i < cycles; i++) begin
      cycle();
      if (int'(out) == level) hi++;
    end
  endtask

  initial begin
    int n, hi, tot;
    bit found;
    model_reset();
    #1;
    chk("reset_out", out, 0);
    chk("reset_strobe", step_strobe, 0);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    rst_n  = 1'b1;

    // default voice: 8-clk steps, 64-clk period, half high
    pulse_trigger();
    wait_strobe(40, n);      chk("first_step_2046", n, 8);
    wait_strobe(40, n);      chk("step_2046", n, 8);
    count_high(128, 15, hi); chk("high_duty2", hi, 64);

    // duty sweep at volume 9
    volume = 4'd9;
    for (int d = 0; d < 4; d++) begin
      duty_cycle = 2'(d);
      count_high(128, 9, hi);
      chk("high_duty_sweep", hi, 2 * high_steps(d) * 8);
      repeat (172) cycle();
    end

    // freq extremes
    freq = 11'd0;
    pulse_trigger();
    wait_strobe(9000, n);    chk("step_freq0", n, 8192);
    freq = 11'd2047; duty_cycle = 2'd2;
    pulse_trigger();
    wait_strobe(20, n);      chk("first_step_2047", n, 4);
    wait_strobe(20, n);      chk("step_2047", n, 4);
    count_high(128, 9, hi);  chk("high_2047", hi, 64);

    // freq change mid-step applies only at reload
    freq = 11'd2046;
    pulse_trigger();
    wait_strobe(40, n);
    repeat (3) cycle();
    freq = 11'd2044;
    wait_strobe(40, n);      chk("old_freq_finish", n, 5);
    wait_strobe(40, n);      chk("new_freq_step", n, 16);

    // trigger coincident with expiry at phase 5
    freq = 11'd2046;
    pulse_trigger();
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_phase == 5 && m_cnt == m_period - 1) found = 1;
      else cycle();
    end
    chk("reach_phase5_expiry", int'(found), 1);
    pulse_trigger();
    chk("trig_no_strobe", step_strobe, 0);
    wait_strobe(40, n);      chk("step_after_trig", n, 8);

    // enable gap of 20 clocks mid-step
    repeat (3) cycle();
    enable = 1'b0;
    cycle();
    chk("disabled_out", out, 0);
    repeat (19) cycle();
    enable = 1'b1;
    wait_strobe(40, n);      chk("gap_shift", 3 + 20 + n, 28);

    // async reset mid-period
    volume = 4'd15;
    pulse_trigger();
    repeat (2) cycle();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_out", out, 0);
    chk("async_rst_strobe", step_strobe, 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("post_rst_phase0_out", out, 15);
    wait_strobe(40, n);      chk("post_rst_step", n + 1, 9);

    // randomised traffic
    tot = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99, 0) < 2)  trigger = 1'b1;
      if ($urandom_range(99, 0) < 3)  enable = ~enable;
      if ($urandom_range(99, 0) < 1)  freq = FW'($urandom_range(2047, 2036));
      if ($urandom_range(99, 0) < 5)  duty_cycle = 2'($urandom_range(3, 0));
      if ($urandom_range(99, 0) < 5)  volume = VW'($urandom_range(15, 0));
      cycle();
      trigger = 1'b0;
      if (step_strobe) tot++;
    end
    chk("random_saw_steps", int'(tot > 0), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
